// File: rtl/decode_hazard_stage.sv
// Decode stage: bypassed register file, branch/jr resolution with forwarding,
// load-use and branch hazard detection, and the ID/EX pipeline register.
module decode_hazard_stage #(
  parameter int unsigned  DATA_W   = 32,
  parameter int unsigned  NREG     = 32,
  parameter int unsigned  CTRL_W   = 16,
  parameter bit           BR_FWD_E = 1'b1,
  localparam int unsigned AW       = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_d_valid,
  input  logic [AW-1:0]     i_d_rs,
  input  logic [AW-1:0]     i_d_rt,
  input  logic [AW-1:0]     i_d_dst,
  input  logic              i_d_uses_rs,
  input  logic              i_d_uses_rt,
  input  logic              i_d_regwrite,
  input  logic              i_d_is_load,
  input  logic [1:0]        i_d_br_op,
  input  logic [15:0]       i_d_imm,
  input  logic [31:0]       i_d_pc4,
  input  logic [CTRL_W-1:0] i_d_ctrl,
  input  logic [DATA_W-1:0] i_e_result,
  input  logic              i_m_valid,
  input  logic              i_m_regwrite,
  input  logic              i_m_is_load,
  input  logic [AW-1:0]     i_m_dst,
  input  logic [DATA_W-1:0] i_m_result,
  input  logic              i_w_regwrite,
  input  logic [AW-1:0]     i_w_dst,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic              i_stall_e,
  input  logic              i_flush,
  output logic              o_stall_d,
  output logic              o_redirect,
  output logic [31:0]       o_redirect_pc,
  output logic              o_e_valid,
  output logic              o_e_regwrite,
  output logic              o_e_is_load,
  output logic [AW-1:0]     o_e_dst,
  output logic [DATA_W-1:0] o_e_rs_data,
  output logic [DATA_W-1:0] o_e_rt_data,
  output logic [DATA_W-1:0] o_e_imm,
  output logic [31:0]       o_e_pc4,
  output logic [CTRL_W-1:0] o_e_ctrl,
  output logic [1:0]        o_e_fwd_a,
  output logic [1:0]        o_e_fwd_b
);

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JR   = 2'b11;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rs_rf, rt_rf, rs_br, rt_br, imm_sext;
  logic              e_rs, e_rt, m_rs, m_rt;
  logic              br_rs_used, br_rt_used, rs_br_stall, rt_br_stall;
  logic              load_use, br_stall, hazard, taken;
  logic [1:0]        fwd_a_d, fwd_b_d;
  logic [31:0]       br_target;

  // Register file storage; register 0 is never written.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (i_w_regwrite && (i_w_dst != '0)) begin
      rf_q[i_w_dst] <= i_w_data;
    end
  end

  // Read ports with write-through bypass from W.
  always_comb begin
    rs_rf = rf_q[i_d_rs];
    rt_rf = rf_q[i_d_rt];
    if (i_d_rs == '0)                               rs_rf = '0;
    else if (i_w_regwrite && (i_w_dst == i_d_rs))   rs_rf = i_w_data;
    if (i_d_rt == '0)                               rt_rf = '0;
    else if (i_w_regwrite && (i_w_dst == i_d_rt))   rt_rf = i_w_data;
  end

  // Producer matches in E and M, ignoring register 0.
  always_comb begin
    e_rs = o_e_valid && o_e_regwrite && (o_e_dst == i_d_rs) && (i_d_rs != '0);
    e_rt = o_e_valid && o_e_regwrite && (o_e_dst == i_d_rt) && (i_d_rt != '0);
    m_rs = i_m_valid && i_m_regwrite && (i_m_dst == i_d_rs) && (i_d_rs != '0);
    m_rt = i_m_valid && i_m_regwrite && (i_m_dst == i_d_rt) && (i_d_rt != '0);
  end

  // Branch operand selection: nearest producer wins, loads cannot forward.
  always_comb begin
    rs_br       = rs_rf;
    rt_br       = rt_rf;
    rs_br_stall = 1'b0;
    rt_br_stall = 1'b0;
    if (e_rs) begin
      rs_br       = i_e_result;
      rs_br_stall = o_e_is_load || !BR_FWD_E;
    end else if (m_rs) begin
      rs_br       = i_m_result;
      rs_br_stall = i_m_is_load;
    end
    if (e_rt) begin
      rt_br       = i_e_result;
      rt_br_stall = o_e_is_load || !BR_FWD_E;
    end else if (m_rt) begin
      rt_br       = i_m_result;
      rt_br_stall = i_m_is_load;
    end
  end

  always_comb begin
    br_rs_used = (i_d_br_op != BR_NONE);
    br_rt_used = (i_d_br_op == BR_BEQ) || (i_d_br_op == BR_BNE);
    load_use   = o_e_is_load && ((i_d_uses_rs && e_rs) || (i_d_uses_rt && e_rt));
    br_stall   = (br_rs_used && rs_br_stall) || (br_rt_used && rt_br_stall);
    hazard     = i_d_valid && (load_use || br_stall);
    o_stall_d  = hazard || i_stall_e;
  end

  always_comb begin
    taken = 1'b0;
    case (i_d_br_op)
      BR_BEQ:  taken = (rs_br == rt_br);
      BR_BNE:  taken = (rs_br != rt_br);
      BR_JR:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
    br_target     = i_d_pc4 + {{14{i_d_imm[15]}}, i_d_imm, 2'b00};
    o_redirect_pc = (i_d_br_op == BR_JR) ? rs_br[31:0] : br_target;
    o_redirect    = i_d_valid && taken && !o_stall_d && !i_flush;
  end

  // E operand select for the instruction entering E.
  always_comb begin
    fwd_a_d  = 2'b00;
    fwd_b_d  = 2'b00;
    if (i_d_uses_rs && e_rs)      fwd_a_d = 2'b01;
    else if (i_d_uses_rs && m_rs) fwd_a_d = 2'b10;
    if (i_d_uses_rt && e_rt)      fwd_b_d = 2'b01;
    else if (i_d_uses_rt && m_rt) fwd_b_d = 2'b10;
    imm_sext = {{(DATA_W-16){i_d_imm[15]}}, i_d_imm};
  end

  // ID/EX register: flush beats downstream stall, which beats bubble/load.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_e_valid    <= 1'b0;
      o_e_regwrite <= 1'b0;
      o_e_is_load  <= 1'b0;
      o_e_dst      <= '0;
      o_e_rs_data  <= '0;
      o_e_rt_data  <= '0;
      o_e_imm      <= '0;
      o_e_pc4      <= '0;
      o_e_ctrl     <= '0;
      o_e_fwd_a    <= '0;
      o_e_fwd_b    <= '0;
    end else if (i_flush) begin
      o_e_valid    <= 1'b0;
      o_e_regwrite <= 1'b0;
      o_e_is_load  <= 1'b0;
    end else if (!i_stall_e) begin
      if (hazard || !i_d_valid) begin
        o_e_valid    <= 1'b0;
        o_e_regwrite <= 1'b0;
        o_e_is_load  <= 1'b0;
      end else begin
        o_e_valid    <= 1'b1;
        o_e_regwrite <= i_d_regwrite;
        o_e_is_load  <= i_d_is_load;
        o_e_dst      <= i_d_dst;
        o_e_rs_data  <= rs_rf;
        o_e_rt_data  <= rt_rf;
        o_e_imm      <= imm_sext;
        o_e_pc4      <= i_d_pc4;
        o_e_ctrl     <= i_d_ctrl;
        o_e_fwd_a    <= fwd_a_d;
        o_e_fwd_b    <= fwd_b_d;
      end
    end
  end

endmodule

// File: doc/decode_hazard_stage.md
# decode_hazard_stage

Parametrised decode stage: register file with write-through bypass, branch/jump-register resolution in D with forwarding, load-use and branch hazard detection with stall/bubble generation, and the ID/EX pipeline register with flush/stall control. Sits between the IF/ID register and the execute stage. Opcode decoding is done by an external decoder that feeds pre-decoded fields into this block.

## Interface
- DATA_W, 32: datapath width; must be ≥32.
- NREG, 32: register count; power of two, ≥2. Localparam AW = $clog2(NREG).
- CTRL_W, 16: width of the opaque E/M/W control bundle, passed through unmodified.
- BR_FWD_E, 1: 1 = branch compare forwards the E-stage ALU result; 0 = stall on an E-stage dependency instead.
---
- i_clk  in  1  clock
- i_nrst  in  1  reset, asynchronous, active-low
- i_d_valid  in  1  IF/ID holds a valid instruction
- i_d_rs, i_d_rt, i_d_dst  in  AW  source and destination register indices
- i_d_uses_rs, i_d_uses_rt, i_d_regwrite, i_d_is_load  in  1  decoded attributes
- i_d_br_op  in  2  00 none, 01 beq, 10 bne, 11 jr
- i_d_imm  in  16  immediate
- i_d_pc4  in  32  PC+4
- i_d_ctrl  in  CTRL_W  control bundle
- i_e_result  in  DATA_W  E-stage ALU result
- i_m_valid, i_m_regwrite, i_m_is_load  in  1  M-stage attributes
- i_m_dst  in  AW  M-stage destination register
- i_m_result  in  DATA_W  M-stage ALU result
- i_w_regwrite  in  1  W-stage write enable
- i_w_dst  in  AW  W-stage destination register
- i_w_data  in  DATA_W  W-stage write data
- i_stall_e  in  1  downstream stall; hold ID/EX
- i_flush  in  1  kill the D instruction
- o_stall_d  out  1  hold PC and IF/ID
- o_redirect  out  1  taken branch/jr
- o_redirect_pc  out  32  target address
- o_e_valid, o_e_regwrite, o_e_is_load  out  1  ID/EX attributes
- o_e_dst  out  AW  ID/EX destination register
- o_e_rs_data, o_e_rt_data  out  DATA_W  operand data
- o_e_imm  out  DATA_W  sign-extended immediate
- o_e_pc4  out  32  ID/EX PC+4
- o_e_ctrl  out  CTRL_W  ID/EX control bundle
- o_e_fwd_a, o_e_fwd_b  out  2  E operand select: 00 reg, 01 from M, 10 from W

## Operation
- Register file: NREG×DATA_W, 2 read ports, 1 write port. Writes on posedge when i_w_regwrite and i_w_dst≠0. Register 0 always reads 0. Read bypass: if addr==i_w_dst, i_w_regwrite=1 and addr≠0, return i_w_data.
- Dependency signals (r≠0 and used):
  - depE(r) = o_e_valid & o_e_regwrite & o_e_dst==r
  - depM(r) = i_m_valid & i_m_regwrite & i_m_dst==r
- Load-use hazard: depE on a used source with o_e_is_load.
- Branch operands (rs; also rt for beq/bne), first match wins:
  - depE: stall if o_e_is_load or BR_FWD_E=0; otherwise use i_e_result.
  - depM: stall if i_m_is_load; otherwise use i_m_result.
  - Otherwise use the register-file value (including bypass).
- hazard = i_d_valid & (load-use | branch stall).
- o_stall_d = hazard | i_stall_e.
- Taken: beq equal, bne not equal, jr always.
- o_redirect = i_d_valid & taken & ~o_stall_d & ~i_flush.
- o_redirect_pc:
  - beq/bne: i_d_pc4 + (sext(imm)<<2), mod 2^32.
  - jr: forwarded rs[31:0].
- Sequential successor (delay slot) is not squashed here.
- Per source, E forward select: 01 if depE, else 10 if depM, else 00.
- ID/EX update, priority order:
  - i_flush: o_e_valid, o_e_regwrite, o_e_is_load ← 0.
  - i_stall_e: hold everything.
  - hazard or ~i_d_valid: bubble (same three bits ← 0; other fields don't care).
  - Otherwise load all D values; o_e_rs_data/o_e_rt_data take register-file (bypassed) values.

## Timing
- Reset: every output register 0; register file all 0; combinational outputs follow from the zeroed state (o_stall_d=0, o_redirect=0).
- D→E latency 1 cycle.
- Redirect and stall are combinational in D.
- Load-use costs exactly 1 bubble.
- Branch on an E-stage load costs 2 stall cycles.
- Branch on an M-stage load, or on an E-stage ALU result with BR_FWD_E=0, costs 1 stall cycle.
- Same-cycle W write and D read of the same register: D sees the new value.
- Flush with i_stall_e: flush wins.
- Reset asserted mid-stall: immediate clear; no residual bubble.

## Test plan
- W writes r5=0x1234 while D reads r5 -> o_e_rs_data=0x1234 next cycle; writing r0=0xFFFF -> r0 reads 0.
- E is load to r3, D is add using r3 -> o_stall_d=1 for 1 cycle, bubble (o_e_valid=0), then issue with o_e_fwd_a=10.
- E is ALU op to r4 with i_e_result=7, D is beq r4,r0 with imm=-1, pc4=0x100 -> BR_FWD_E=1: no stall, o_redirect=0; i_e_result=0 gives o_redirect=1, target 0xFC. BR_FWD_E=0: 1 stall cycle.
- E is load to r2, D is jr r2 -> 2 stall cycles, then o_redirect=1 with o_redirect_pc = loaded value (via W bypass).
- i_stall_e held 3 cycles with a valid D instruction -> ID/EX unchanged, o_stall_d=1; i_flush during stall -> o_e_valid=0 next cycle.
- Async reset mid-operation -> all outputs and registers 0 before the next clock edge.
